md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- HI/LO multiply-divide unit in the EX stage, directly downstream of the decoder.
- Consumes the decoder's mult, div, mdsign, hiloren and hilowen controls, plus the rs/rt operand values.
- Executes MULT/MULTU with a short fixed latency and DIV/DIVU with an iterative radix-2 divider.
- Owns the architectural HI/LO registers, stalls the pipeline while busy, and supplies MFHI/MFLO read data.

Parameters:
MUL_CYCLES, 1, registered multiply latency in cycles, legal range 1..4
DIV_ITERS, 32, divider iterations; fixed by the 32-bit datapath and not to be overridden

Ports:
clk  in  1  clock; all state updates on the rising edge
resetn  in  1  asynchronous, active-low reset
valid  in  1  EX stage holds a valid instruction
advance  in  1  EX instruction leaves the stage this cycle
flush  in  1  cancels the EX instruction (exception or eret); overrides everything
mult  in  1  MULT/MULTU, from decoder
div  in  1  DIV/DIVU, from decoder
mdsign  in  1  1 = signed operation
hilowen  in  2  bit0 writes LO, bit1 writes HI; 2'b11 accompanies mult/div
hiloren  in  2  2'b01 reads LO, 2'b10 reads HI
rega  in  32  GPR[rs] value (dividend or multiplicand; MTHI/MTLO source)
regb  in  32  GPR[rt] value (divisor or multiplier)
stall  out  1  hold EX and all upstream stages
rdata  out  32  HI when hiloren[1], else LO; combinational
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE, hi=0, lo=0, counters=0, result registers=0, stall=0. Reset mid-operation discards the operation.
- req = valid & (mult|div) & ~flush.
- stall = req & (state != DONE). It is combinational, so it is high in the accepting IDLE cycle.
- Inputs are stable while stall=1; the pipeline guarantees this.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - On req, latch operands and go to MUL (mult) or DIV (div); counter=0.
  - For signed operations, latch |rega|, |regb| and the sign bits.
- MUL:
  - Compute the 64-bit product, signed (33-bit sign-extended) or unsigned per mdsign.
  - Count MUL_CYCLES cycles, then register {HI,LO}=product and go to DONE.
  - Total stall = MUL_CYCLES+1 cycles.
- DIV:
  - Restoring radix-2 division, one quotient bit per cycle, on 32-bit magnitudes.
  - After DIV_ITERS cycles, apply sign fix and go to DONE. Total stall = 33 cycles.
  - Sign fix: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Div-by-zero: no exception; quotient magnitude 0xFFFFFFFF, remainder = |dividend|, then sign fix.
  - 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- DONE:
  - stall=0; results are held in the result registers.
  - advance & ~flush: commit hi<=result_hi, lo<=result_lo; go to IDLE.
  - ~advance: stay in DONE; no restart, even though req remains high.
- flush in any state: go to IDLE next edge, no HI/LO commit, stall=0 in that cycle.
- MTHI/MTLO: when valid & advance & ~flush & ~mult & ~div, hi<=rega if hilowen[1] and lo<=rega if hilowen[0]. No latency.
- MFHI/MFLO: rdata reads hi/lo directly. HI/LO commit before the next instruction enters EX, so no bypass is needed.
- A write and a read of HI/LO never target the same instruction, so simultaneous write/read ordering is irrelevant.

Decomposition:
- head.vh gains MD_IDLE/MD_MUL/MD_DIV/MD_DONE state encodings (2-bit) and the MD_DIV_ITERS constant.
- One sub-module, div_radix2: start, 32-bit magnitudes in; done, quotient, remainder out; internal 6-bit iteration counter.
- md_unit owns the FSM, sign handling, multiplier, HI/LO and stall logic.

Test Plan:
- Signed MULT rega=0xFFFFFFFF, regb=2, advance when stall drops -> stall high 2 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed DIV rega=-7 (0xFFFFFFF9), regb=2 -> stall high exactly 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF after advance.
- DIVU rega=0x80000000, regb=0 -> lo=0xFFFFFFFF, hi=0x80000000. Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV started with hi=lo=0x12345678; flush at iteration 10 -> stall=0 that cycle, state IDLE, hi/lo unchanged. Then a fresh DIV completes correctly.
- MTHI rega=0xCAFEBABE then back-to-back MFHI -> rdata=0xCAFEBABE.
- DONE held 3 cycles with advance=0 -> no restart, hi/lo unchanged until advance.
- resetn low mid-MUL -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared encodings and helpers for the HI/LO multiply-divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package md_unit_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    localparam int MD_DIV_ITERS = 32;

    // Two's-complement magnitude of a value; unsigned operands pass through untouched.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_unit_div_radix2.sv
// Restoring radix-2 divider on 32-bit magnitudes, one quotient bit per cycle.
// Latency: ITERS cycles after start; done/quotient/remainder are valid combinationally in the last one.
// Backpressure: none; a new start reloads and abandons any division in flight.
module div_radix2
    import md_unit_pkg::*;
#(
    parameter int ITERS = MD_DIV_ITERS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [5:0]  cnt_q;
    logic        busy_q;

    logic [32:0] shifted;
    logic [31:0] sub;
    logic        bit_ok;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    // Partial remainder is always below the divisor, so the shifted value fits in 33 bits
    // and the low 32 bits of the difference are exact whenever the trial succeeds.
    assign shifted = {rem_q, quo_q[31]};
    assign bit_ok  = (shifted >= {1'b0, dvs_q});
    assign sub     = shifted[31:0] - dvs_q;
    assign rem_nxt = bit_ok ? sub : shifted[31:0];
    assign quo_nxt = {quo_q[30:0], bit_ok};

    assign done      = busy_q && (cnt_q == 6'(ITERS - 1));
    assign quotient  = quo_nxt;
    assign remainder = rem_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + 6'd1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage HI/LO multiply-divide unit: MULT/MULTU, DIV/DIVU, MTHI/MTLO, MFHI/MFLO.
// Latency: MUL_CYCLES+1 stall cycles for multiply, DIV_ITERS+1 for divide; HI/LO commit on advance.
// Backpressure: stall holds EX and upstream until results are ready; flush cancels at once.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_ITERS  = MD_DIV_ITERS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic        advance,
    input  logic        flush,
    input  logic        mult,
    input  logic        div,
    input  logic        mdsign,
    input  logic [1:0]  hilowen,
    input  logic [1:0]  hiloren,
    input  logic [31:0] rega,
    input  logic [31:0] regb,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state_q;
    logic [1:0]  cnt_q;
    logic [31:0] mag_a_q;
    logic [31:0] mag_b_q;
    logic        neg_q;
    logic        rneg_q;
    logic [31:0] result_hi_q;
    logic [31:0] result_lo_q;

    logic        req;
    logic        sgn_a;
    logic        sgn_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [63:0] product_mag;
    logic [63:0] product;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        md_unused;

    assign req   = valid & (mult | div) & ~flush;
    assign stall = resetn & req & (state_q != MD_DONE);

    assign sgn_a = mdsign & rega[31];
    assign sgn_b = mdsign & regb[31];
    assign mag_a = md_abs(rega, mdsign);
    assign mag_b = md_abs(regb, mdsign);

    assign div_start = (state_q == MD_IDLE) & req & div & ~mult;

    // Both multiply and divide run on magnitudes; the sign is restored at the end.
    assign product_mag = {32'd0, mag_a_q} * {32'd0, mag_b_q};
    assign product     = neg_q  ? (~product_mag + 64'd1) : product_mag;
    assign quo_fix     = neg_q  ? (~div_quo + 32'd1)     : div_quo;
    assign rem_fix     = rneg_q ? (~div_rem + 32'd1)     : div_rem;

    // LO is the default read target, so hiloren[0] needs no decode.
    assign rdata     = hiloren[1] ? hi : lo;
    assign md_unused = hiloren[0];

    div_radix2 #(
        .ITERS(DIV_ITERS)
    ) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start),
        .dividend (mag_a),
        .divisor  (mag_b),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            result_hi_q <= '0;
            result_lo_q <= '0;
        end else if (flush) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (req) begin
                        mag_a_q <= mag_a;
                        mag_b_q <= mag_b;
                        neg_q   <= sgn_a ^ sgn_b;
                        rneg_q  <= sgn_a;
                        cnt_q   <= '0;
                        state_q <= mult ? MD_MUL : MD_DIV;
                    end
                end
                MD_MUL: begin
                    if (cnt_q == 2'(MUL_CYCLES - 1)) begin
                        result_hi_q <= product[63:32];
                        result_lo_q <= product[31:0];
                        state_q     <= MD_DONE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                MD_DIV: begin
                    if (div_done) begin
                        result_hi_q <= rem_fix;
                        result_lo_q <= quo_fix;
                        state_q     <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    // Holding here with req still high must not restart the operation.
                    if (advance) begin
                        state_q <= MD_IDLE;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (!flush && advance) begin
            if (state_q == MD_DONE) begin
                hi <= result_hi_q;
                lo <= result_lo_q;
            end else if (valid && !mult && !div) begin
                if (hilowen[1]) hi <= rega;
                if (hilowen[0]) lo <= rega;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: reference arithmetic model tracked every cycle plus literal results.
module tb_md_unit;

    localparam int MULC = 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic        advance;
    logic        flush;
    logic        mult;
    logic        div;
    logic        mdsign;
    logic [1:0]  hilowen;
    logic [1:0]  hiloren;
    logic [31:0] rega;
    logic [31:0] regb;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks   = 0;
    int          failures = 0;
    bit          chk_en   = 1'b0;
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;

    always #5 clk = ~clk;

    md_unit #(.MUL_CYCLES(MULC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .valid  (valid),
        .advance(advance),
        .flush  (flush),
        .mult   (mult),
        .div    (div),
        .mdsign (mdsign),
        .hilowen(hilowen),
        .hiloren(hiloren),
        .rega   (rega),
        .regb   (regb),
        .stall  (stall),
        .rdata  (rdata),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // {HI,LO} an instruction must leave behind, from plain integer arithmetic.
    function automatic logic [63:0] model_md(input bit is_mul, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (is_mul) return 64'(sa * sb);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            if (sgn && a[31]) q = 32'd0 - q;
            r = a;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hi_track", 64'(hi), 64'(exp_hi));
            chk("lo_track", 64'(lo), 64'(exp_lo));
            chk("rdata_track", 64'(rdata), 64'(hiloren[1] ? exp_hi : exp_lo));
        end
    end

    // Starts at posedge+1; returns at posedge+1 after the commit has been checked.
    task automatic do_op(input bit is_mul, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [31:0] lit_hi, input logic [31:0] lit_lo,
                         input string name);
        logic [63:0] m;
        int          lat;
        bit          done;
        m       = model_md(is_mul, sgn, a, b);
        valid   = 1'b1;
        mult    = is_mul;
        div     = !is_mul;
        mdsign  = sgn;
        hilowen = 2'b11;
        hiloren = 2'b00;
        rega    = a;
        regb    = b;
        advance = 1'b0;
        lat     = 0;
        done    = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!stall || lat >= 100) begin
                done = 1'b1;
            end else begin
                lat++;
                @(posedge clk);
            end
        end
        chk({name, " stall_cycles"}, 64'(lat), is_mul ? 64'(MULC + 1) : 64'(33));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, " held_stall"}, 64'(stall), 64'd0);
        end
        advance = 1'b1;
        @(posedge clk);
        exp_hi = m[63:32];
        exp_lo = m[31:0];
        #1;
        valid   = 1'b0;
        mult    = 1'b0;
        div     = 1'b0;
        advance = 1'b0;
        hilowen = 2'b00;
        @(negedge clk);
        chk({name, " hi"}, 64'(hi), 64'(lit_hi));
        chk({name, " lo"}, 64'(lo), 64'(lit_lo));
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic [31:0] a, input logic [1:0] wen);
        valid   = 1'b1;
        mult    = 1'b0;
        div     = 1'b0;
        advance = 1'b1;
        hilowen = wen;
        hiloren = 2'b00;
        rega    = a;
        @(posedge clk);
        if (wen[1]) exp_hi = a;
        if (wen[0]) exp_lo = a;
        #1;
        hilowen = 2'b00;
        valid   = 1'b0;
        advance = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn  = 1'b0;
        valid   = 1'b0;
        advance = 1'b0;
        flush   = 1'b0;
        mult    = 1'b0;
        div     = 1'b0;
        mdsign  = 1'b0;
        hilowen = 2'b00;
        hiloren = 2'b00;
        rega    = '0;
        regb    = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset rdata", 64'(rdata), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk_en = 1'b1;

        do_op(1, 1, 32'hFFFF_FFFF, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_s");
        do_op(1, 0, 32'hFFFF_FFFF, 32'd2, 0, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        do_op(1, 1, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0000_0000, "mult_min");
        do_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_s");
        do_op(0, 0, 32'h8000_0000, 32'd0, 0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_zero");
        do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000, "div_ovf");
        do_op(0, 1, 32'd100, 32'hFFFF_FFF9, 0, 32'h0000_0002, 32'hFFFF_FFF2, "div_negb");
        do_op(0, 1, 32'hFFFF_FFFB, 32'd0, 0, 32'hFFFF_FFFB, 32'h0000_0001, "div_s_zero");
        do_op(0, 0, 32'hFFFF_FFFF, 32'd3, 3, 32'h0000_0000, 32'h5555_5555, "divu_hold");
        do_op(1, 1, 32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_hold");

        // Flush a divide ten iterations in.
        mt(32'h1234_5678, 2'b11);
        valid   = 1'b1;
        div     = 1'b1;
        mdsign  = 1'b1;
        hilowen = 2'b11;
        rega    = 32'd100;
        regb    = 32'd7;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("flush busy_before", 64'(stall), 64'd1);
        flush = 1'b1;
        #1;
        chk("flush stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        valid   = 1'b0;
        div     = 1'b0;
        hilowen = 2'b00;
        @(negedge clk);
        chk("flush idle_stall", 64'(stall), 64'd0);
        chk("flush hi", 64'(hi), 64'h1234_5678);
        chk("flush lo", 64'(lo), 64'h1234_5678);
        @(posedge clk);
        #1;
        do_op(0, 1, 32'd100, 32'd7, 0, 32'h0000_0002, 32'h0000_000E, "div_after_flush");

        // MTHI then MFHI back to back, likewise for LO.
        mt(32'hCAFE_BABE, 2'b10);
        valid   = 1'b1;
        advance = 1'b1;
        hiloren = 2'b10;
        rega    = 32'd0;
        @(negedge clk);
        chk("mfhi rdata", 64'(rdata), 64'hCAFE_BABE);
        @(posedge clk);
        #1;
        valid   = 1'b0;
        advance = 1'b0;
        hiloren = 2'b00;
        mt(32'h0BAD_F00D, 2'b01);
        valid   = 1'b1;
        advance = 1'b1;
        hiloren = 2'b01;
        @(negedge clk);
        chk("mflo rdata", 64'(rdata), 64'h0BAD_F00D);
        chk("mflo hi_kept", 64'(hi), 64'hCAFE_BABE);
        @(posedge clk);
        #1;
        valid   = 1'b0;
        advance = 1'b0;
        hiloren = 2'b00;

        // Reset in the middle of a multiply.
        valid   = 1'b1;
        mult    = 1'b1;
        mdsign  = 1'b0;
        hilowen = 2'b11;
        rega    = 32'd9;
        regb    = 32'd9;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        valid  = 1'b0;
        mult   = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        chk("rst_mid stall", 64'(stall), 64'd0);
        chk("rst_mid hi", 64'(hi), 64'd0);
        chk("rst_mid lo", 64'(lo), 64'd0);
        chk("rst_mid rdata", 64'(rdata), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        do_op(1, 0, 32'd3, 32'd5, 0, 32'h0000_0000, 32'h0000_000F, "mult_after_reset");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
